// File: rtl/tree_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// tree_accumulator_pkg
// Shared datapath definitions for the dot-product accumulator and the other
// requantizers that sit behind the adder tree.
//   DEF_IL / DEF_FL : default activation format (integer / fractional bits)
//   DW, PW, TW      : activation width, product width, tree output width
//   acc_state_e     : accumulator sequencing states
//   rq_*            : round-half-up and saturate helpers. They work on 64-bit
//                     signed values, so any accumulator up to 64 bits wide
//                     can use them after sign extension.
// -----------------------------------------------------------------------------
package tree_accumulator_pkg;

    localparam int DEF_IL = 4;
    localparam int DEF_FL = 16;
    localparam int DW     = DEF_IL + DEF_FL;
    localparam int PW     = 2 * DW;
    localparam int TW     = 4 + PW;
    localparam int RQ_W   = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    // Add half an output LSB, then drop fl fractional bits (floor), which
    // gives round-half-up for both signs.
    function automatic logic signed [RQ_W-1:0] rq_round(
        input logic signed [RQ_W-1:0] x,
        input int                     fl
    );
        logic signed [RQ_W-1:0] half;
        half = (fl > 0) ? (64'sd1 <<< (fl - 1)) : 64'sd0;
        return (x + half) >>> fl;
    endfunction

    function automatic logic signed [RQ_W-1:0] rq_hi(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [RQ_W-1:0] rq_lo(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

    // True when r does not fit a dw-bit signed word.
    function automatic logic rq_saturates(
        input logic signed [RQ_W-1:0] r,
        input int                     dw
    );
        return (r > rq_hi(dw)) || (r < rq_lo(dw));
    endfunction

    // Clamp r into the dw-bit signed range; caller keeps the low dw bits.
    function automatic logic signed [RQ_W-1:0] rq_clamp(
        input logic signed [RQ_W-1:0] r,
        input int                     dw
    );
        if (r > rq_hi(dw)) return rq_hi(dw);
        if (r < rq_lo(dw)) return rq_lo(dw);
        return r;
    endfunction

endpackage

// File: rtl/tree_accumulator_result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Two-entry first-word-fall-through FIFO for finished results.
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push        : write push_data this cycle
//   push_data   : entry to store
//   pop         : consume the head entry this cycle
//   head_data   : current head entry (meaningful while count != 0)
//   count       : number of valid entries, 0..2
// A push and a pop in the same cycle leave count unchanged, even when full.
// -----------------------------------------------------------------------------
module result_fifo #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (count_reg != 2'd0);
    assign do_push = push && ((count_reg != 2'd2) || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [W-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
    assign count     = count_reg;

endmodule

// File: rtl/tree_accumulator.sv
// -----------------------------------------------------------------------------
// tree_accumulator
// Accumulates 16-term partial sums from the adder tree into one dot-product
// result per group, rounds/saturates it to the IL.FL activation format and
// queues up to two results behind a valid/ready handshake.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : partial-sum beat handshake
//   in_first/in_last    : beat opens / closes a group
//   in_data             : signed tree sum, 2*FL fractional bits
//   out_valid/out_ready : result handshake
//   out_data            : signed result, FL fractional bits
//   out_sat             : head result was saturated (conversion or accumulator)
//   err                 : sticky protocol error, cleared only by reset
// Pipeline: closing beat accepted in cycle t -> acc holds final sum in t+1,
// where it is converted and written into the FIFO -> out_valid in t+2.
// Accumulator width must not exceed 64 bits (rq_* helper width).
// -----------------------------------------------------------------------------
module tree_accumulator
    import tree_accumulator_pkg::*;
#(
    parameter int IL      = DEF_IL,
    parameter int FL      = DEF_FL,
    parameter int ACC_EXT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [4+2*(IL+FL)-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IL+FL-1:0]          out_data,
    output logic                      out_sat,
    output logic                      err
);

    localparam int OUT_W = IL + FL;
    localparam int IN_W  = 4 + 2 * OUT_W;
    localparam int ACC_W = ACC_EXT + IN_W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    acc_state_e              state_reg;
    logic [ACC_W-1:0]        acc_reg;
    logic                    ovf_reg;
    logic                    pend_reg;     // final sum sits in acc_reg, convert this cycle
    logic                    err_reg;
    logic [OUT_W-1:0]        hold_data_reg;
    logic                    hold_sat_reg;

    logic                    accept;
    logic [ACC_W-1:0]        in_ext;
    logic [ACC_W-1:0]        sum_raw;
    logic [ACC_W-1:0]        sum_next;
    logic                    add_ovf;
    logic signed [RQ_W-1:0]  acc_wide;
    logic signed [RQ_W-1:0]  rounded;
    logic [OUT_W-1:0]        conv_data;
    logic                    conv_sat;
    logic [1:0]              fifo_count;
    logic [OUT_W:0]          head_word;
    logic                    pop;

    // A result in the conversion slot is counted as occupied FIFO space, so
    // the write one cycle later always finds room.
    assign in_ready = ({1'b0, fifo_count} + {2'b00, pend_reg}) < 3'd2;
    assign accept   = in_valid & in_ready;

    assign in_ext  = {{ACC_EXT{in_data[IN_W-1]}}, in_data};
    assign sum_raw = acc_reg + in_ext;
    // Overflow only when both operands share a sign the result lost.
    assign add_ovf = (acc_reg[ACC_W-1] == in_ext[ACC_W-1]) &&
                     (sum_raw[ACC_W-1] != acc_reg[ACC_W-1]);
    assign sum_next = !add_ovf ? sum_raw : (acc_reg[ACC_W-1] ? ACC_MIN : ACC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            pend_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            pend_reg <= 1'b0;
            if (accept) begin
                if (in_first) begin
                    // A first inside an open group abandons that group.
                    if (state_reg == ACCUM) err_reg <= 1'b1;
                    acc_reg <= in_ext;
                    ovf_reg <= 1'b0;
                    if (in_last) begin
                        pend_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        state_reg <= ACCUM;
                    end
                end else if (state_reg == IDLE) begin
                    err_reg <= 1'b1;       // orphan beat, dropped
                end else begin
                    acc_reg <= sum_next;
                    ovf_reg <= ovf_reg | add_ovf;
                    if (in_last) begin
                        pend_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
            end
        end
    end

    // Conversion reads acc_reg/ovf_reg while pend_reg is set; a new group
    // starting in that same cycle only overwrites them at its end.
    assign acc_wide  = {{(RQ_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg};
    assign rounded   = rq_round(acc_wide, FL);
    assign conv_data = OUT_W'(rq_clamp(rounded, OUT_W));
    assign conv_sat  = rq_saturates(rounded, OUT_W) | ovf_reg;

    result_fifo #(
        .W(OUT_W + 1)
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pend_reg),
        .push_data ({conv_data, conv_sat}),
        .pop       (pop),
        .head_data (head_word),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & out_ready;

    // Outputs keep showing the last consumed result while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data_reg <= '0;
            hold_sat_reg  <= 1'b0;
        end else if (pop) begin
            hold_data_reg <= head_word[OUT_W:1];
            hold_sat_reg  <= head_word[0];
        end
    end

    assign out_data = out_valid ? head_word[OUT_W:1] : hold_data_reg;
    assign out_sat  = out_valid ? head_word[0]       : hold_sat_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_tree_accumulator.sv
// -----------------------------------------------------------------------------
// tb_tree_accumulator
// Directed and randomized scenarios for tree_accumulator. Expected results
// come from a group-level model using plain 64-bit integer arithmetic.
// -----------------------------------------------------------------------------
module tb_tree_accumulator;

    localparam int IL   = 4;
    localparam int FL   = 16;
    localparam int OW   = IL + FL;
    localparam int IW   = 4 + 2 * OW;
    localparam int ACCW = 8 + IW;
    localparam longint ACC_MAX = (longint'(1) <<< (ACCW - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACCW - 1));
    localparam longint OUT_MAX = (longint'(1) <<< (OW - 1)) - 1;
    localparam longint OUT_MIN = -(longint'(1) <<< (OW - 1));

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, in_first, in_last;
    logic [IW-1:0] in_data;
    logic          out_valid, out_ready, out_sat, err;
    logic [OW-1:0] out_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tree_accumulator #(.IL(IL), .FL(FL), .ACC_EXT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .err       (err)
    );

    // ---------------- reference model ----------------
    longint      m_acc;
    bit          m_ovf, m_in_group, m_err;
    logic [OW:0] exp_q[$];
    logic [OW:0] obs_q[$];

    function automatic void model_reset();
        m_acc = 0; m_ovf = 0; m_in_group = 0; m_err = 0;
        exp_q.delete();
    endfunction

    function automatic void model_emit();
        longint        r;
        bit            s;
        logic [OW-1:0] o;
        r = (m_acc + 32768) >>> FL;  // floor((acc + half LSB) / 2^FL)
        s = m_ovf;
        if (r > OUT_MAX) begin r = OUT_MAX; s = 1; end
        else if (r < OUT_MIN) begin r = OUT_MIN; s = 1; end
        o = r[OW-1:0];
        exp_q.push_back({o, s});
    endfunction

    function automatic void model_beat(logic [IW-1:0] d, bit f, bit l);
        longint v;
        v = longint'({{(64-IW){d[IW-1]}}, d});
        if (f) begin
            if (m_in_group) m_err = 1;
            m_acc = v; m_ovf = 0;
            if (l) begin model_emit(); m_in_group = 0; end
            else m_in_group = 1;
        end else if (!m_in_group) begin
            m_err = 1;
        end else begin
            m_acc = m_acc + v;
            if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_ovf = 1; end
            else if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_ovf = 1; end
            if (l) begin model_emit(); m_in_group = 0; end
        end
    endfunction

    // Collect every consumed result, sampled well clear of the clock edges.
    always begin
        @(negedge clk); #1;
        if (!reset && out_valid && out_ready) obs_q.push_back({out_data, out_sat});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    // Called on a negedge; returns on the negedge after the beat was taken.
    task automatic send_beat(input logic [IW-1:0] d, input bit f, input bit l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_first = f; in_last = l;
        while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL beat_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end else begin
            model_beat(d, f, l);
        end
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (obs_q.size() < n && k < 300) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [IW-1:0] to_beat(input longint v);
        return v[IW-1:0];
    endfunction

    function automatic logic [IW-1:0] rand_beat();
        longint v;
        int     sel;
        v   = longint'({$urandom(), $urandom()});
        sel = $urandom_range(0, 2);
        v   = v >>> ((sel == 0) ? 34 : (sel == 1) ? 30 : 20);
        return v[IW-1:0];
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat: got %b required 0", out_sat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        logic [OW:0] got;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(to_beat(64'h1_0000_0000), i == 0, i == 3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: out_valid=%b one cycle after last, required 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid=%b two cycles after last, required 1", out_valid); end
        checks++; if ({out_data, out_sat} !== {20'h40000, 1'b0}) begin errors++; $display("FAIL basic_head: got %h/%b required 40000/0", out_data, out_sat); end
        wait_results(1);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d results required 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front(); checks++;
            if (got !== {20'h40000, 1'b0}) begin errors++; $display("FAIL basic_result: got %h/%b required 40000/0", got[OW:1], got[0]); end
            else $display("basic: result %h sat %b", got[OW:1], got[0]);
        end
        checks++; if ({out_valid, out_data} !== {1'b0, 20'h40000}) begin errors++; $display("FAIL basic_hold: got valid=%b data=%h required 0/40000", out_valid, out_data); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        logic [OW:0] got;
        logic [OW:0] want [2];
        want[0] = {20'h7FFFF, 1'b1};
        want[1] = {20'h80000, 1'b1};
        for (int i = 0; i < 3; i++) send_beat(to_beat(64'sd3 <<< 32), i == 0, i == 2);
        for (int i = 0; i < 3; i++) send_beat(to_beat(-(64'sd3 <<< 32)), i == 0, i == 2);
        wait_results(2);
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL sat_count: got %0d results required 2", obs_q.size()); end
        for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
            got = obs_q.pop_front(); checks++;
            if (got !== want[i]) begin errors++; $display("FAIL sat_result%0d: got %h/%b required %h/%b", i, got[OW:1], got[0], want[i][OW:1], want[i][0]); end
            else $display("saturation: result %h sat %b", got[OW:1], got[0]);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_rounding();
        logic [OW:0]   got;
        longint        rin  [4] = '{64'sd32768, 64'sd32767, -64'sd32768, -64'sd32769};
        logic [OW-1:0] rout [4] = '{20'h00001, 20'h00000, 20'h00000, 20'hFFFFF};
        for (int i = 0; i < 4; i++) send_beat(to_beat(rin[i]), 1'b1, 1'b1);
        wait_results(4);
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL round_count: got %0d results required 4", obs_q.size()); end
        for (int i = 0; i < 4 && obs_q.size() > 0; i++) begin
            got = obs_q.pop_front(); checks++;
            if (got !== {rout[i], 1'b0}) begin errors++; $display("FAIL round_result%0d: got %h/%b required %h/0", i, got[OW:1], got[0], rout[i]); end
            else $display("rounding: in %0d -> result %h", rin[i], got[OW:1]);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [OW:0]   got, want;
        logic [IW-1:0] third;
        out_ready = 1'b0;
        send_beat(rand_beat(), 1'b1, 1'b1);
        send_beat(rand_beat(), 1'b1, 1'b1);
        third = rand_beat();
        in_valid = 1'b1; in_data = third; in_first = 1'b1; in_last = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_a: got %b required 0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_b: got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || obs_q.size() != 0) begin errors++; $display("FAIL b2b_held: out_valid=%b popped=%0d required 1/0", out_valid, obs_q.size()); end
        out_ready = 1'b1;
        send_beat(third, 1'b1, 1'b1);
        wait_results(3);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c: got %b required 1", in_ready); end
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d results required 3", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL b2b_result: got %h/%b required %h/%b", got[OW:1], got[0], want[OW:1], want[0]); end
            else $display("back_to_back: result %h sat %b", got[OW:1], got[0]);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_acc_overflow();
        logic [OW:0] got, want;
        // Clamp at the positive limit, then pull back to -1: only ovf can flag it.
        for (int i = 0; i < 260; i++) send_beat(to_beat((64'sd1 <<< 43) - 1), i == 0, 1'b0);
        for (int i = 0; i < 256; i++) send_beat(to_beat(-(64'sd1 <<< 43)), 1'b0, i == 255);
        wait_results(1);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL accovf_count: got %0d results required 1", obs_q.size()); end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL accovf_result: got %h/%b required %h/%b", got[OW:1], got[0], want[OW:1], want[0]); end
            else $display("acc_overflow: result %h sat %b", got[OW:1], got[0]);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_protocol();
        logic [OW:0] got, want;
        send_beat(to_beat(64'h1_0000_0000), 1'b0, 1'b1);
        wait_results(0);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL proto_orphan: got %0d results required 0", obs_q.size()); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL proto_err_a: got %b required 1", err); end
        send_beat(to_beat(64'h5_0000_0000), 1'b1, 1'b0);
        send_beat(to_beat(64'h2_0000_0000), 1'b0, 1'b0);
        send_beat(to_beat(64'h0_8000_0000), 1'b1, 1'b0);
        send_beat(to_beat(64'h1_4000_0000), 1'b0, 1'b1);
        wait_results(1);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL proto_count: got %0d results required 1", obs_q.size()); end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want || got !== {20'h1C000, 1'b0}) begin errors++; $display("FAIL proto_result: got %h/%b required %h/%b", got[OW:1], got[0], want[OW:1], want[0]); end
            else $display("protocol: result %h sat %b", got[OW:1], got[0]);
        end
        checks++; if (err !== 1'b1 || m_err !== 1'b1) begin errors++; $display("FAIL proto_err_b: got %b required 1", err); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_after_last();
        logic [OW:0] got;
        bit          seen = 0;
        send_beat(to_beat(64'h1_0000_0000), 1'b1, 1'b1);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        obs_q.delete();
        checks++; if ({in_ready, out_valid, out_sat, err} !== 4'b1000) begin errors++; $display("FAIL rst_flags: got ready/valid/sat/err=%b%b%b%b required 1000", in_ready, out_valid, out_sat, err); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data: got %h required 0", out_data); end
        repeat (5) begin @(negedge clk); if (out_valid !== 1'b0) seen = 1; end
        checks++; if (seen || obs_q.size() != 0) begin errors++; $display("FAIL rst_flush: out_valid seen=%0d results=%0d required 0/0", seen, obs_q.size()); end
        send_beat(to_beat(64'h2_8000_0000), 1'b1, 1'b0);
        send_beat(to_beat(-64'sh0_C000_0000), 1'b0, 1'b1);
        wait_results(1);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL rst_count: got %0d results required 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front(); checks++;
            if (got !== {20'h1C000, 1'b0}) begin errors++; $display("FAIL rst_result: got %h/%b required 1c000/0", got[OW:1], got[0]); end
            else $display("reset_after_last: result %h sat %b", got[OW:1], got[0]);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [OW:0] got, want;
        bit          rnd_active = 1;
        int          len, nexp;
        fork
            begin
                while (rnd_active) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int g = 0; g < 25; g++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) send_beat(rand_beat(), i == 0, i == len - 1);
        end
        rnd_active = 0;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        nexp = exp_q.size();
        wait_results(nexp);
        checks++; if (obs_q.size() != nexp) begin errors++; $display("FAIL rand_count: got %0d results required %0d", obs_q.size(), nexp); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL rand_result: got %h/%b required %h/%b", got[OW:1], got[0], want[OW:1], want[0]); end
            else $display("random: result %h sat %b", got[OW:1], got[0]);
        end
        checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err: got %b required %b", err, m_err); end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_back_to_back();
        test_acc_overflow();
        test_protocol();
        test_reset_after_last();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tree_accumulator.md
Name: tree_accumulator

Overview:
- Sits directly downstream of the 16-input pipelined adder tree in the dot-product datapath.
- Accumulates successive 16-term partial sums into one dot-product result per group (groups longer than 16 terms).
- Rounds and saturates each result back to the IL+FL activation format.
- Buffers up to two results behind a valid/ready output handshake.

Parameters:
IL, 4, integer bits of the activation format
FL, 16, fractional bits of the activation format
ACC_EXT, 8, guard bits added above the tree output width in the accumulator

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  partial-sum beat present
in_ready  output  1  block can accept a beat this cycle
in_first  input  1  beat opens a new group
in_last  input  1  beat closes the current group
in_data  input  4+2*(IL+FL)  signed tree sum, 2*FL fractional bits
out_valid  output  1  result available at FIFO head
out_ready  input  1  consumer takes result
out_data  output  IL+FL  signed rounded/saturated result, FL fractional bits
out_sat  output  1  head result was saturated (conversion or accumulator)
err  output  1  sticky protocol error

Behaviour:
- Interface: clk, single clock; reset synchronous, active-high. On reset: in_ready=1, out_valid=0, out_data=0, out_sat=0, err=0, accumulator=0, FIFO empty, FSM=IDLE.
- A beat is accepted when in_valid & in_ready.
- Accumulator width: ACCW = ACC_EXT+4+2*(IL+FL) (52 at defaults). in_data is sign-extended to ACCW.
- FSM states:
  - IDLE: accepted first → acc <= in_data, ovf <= 0, go to ACCUM. If last is also set, the result is emitted (single-beat group) and the FSM stays in IDLE.
  - IDLE: accepted beat without first → beat dropped, err <= 1.
  - ACCUM: accepted beat without first → acc <= acc + in_data.
  - ACCUM: accepted beat with last → result emitted, go to IDLE.
  - ACCUM: accepted first → previous group discarded (no output), err <= 1, acc <= in_data.
- Accumulator overflow: detected from operand signs versus result sign. On overflow, acc clamps to the ACCW max/min value and ovf <= 1 for the group.
- Conversion stage (registered, one cycle after the closing accumulate):
  - r = (acc + 2^(FL-1)) >>> FL, arithmetic shift; round half up.
  - If r > 2^(IL+FL-1)-1 → out = 2^(IL+FL-1)-1, sat=1.
  - If r < -2^(IL+FL-1) → out = -2^(IL+FL-1), sat=1.
  - Otherwise out = r[IL+FL-1:0], sat = ovf.
- Latency: last accepted in cycle t → accumulate register updates at end of t → conversion register at end of t+1 → FIFO write. out_valid rises in t+2 if the FIFO was empty.
- Output FIFO: 2 entries {data, sat}.
  - out_data/out_sat are driven from the head entry while out_valid=1; they hold the last popped value otherwise.
  - Pop on out_valid & out_ready. A simultaneous push and pop is legal and the count is unchanged.
- Backpressure: in_ready = (fifo_count + results in flight in the conversion stage) < 2. This guarantees a FIFO write is never dropped.
  - in_ready deasserts for all beats, not only last beats.
  - in_ready is combinational from registered state only; it never depends on in_valid.
- err is cleared only by reset.
- Reset mid-group: the accumulator, the in-flight result and the FIFO contents are all discarded.

Decomposition:
- Shared package (datapath package):
  - width constants: DW=IL+FL, PW=2*DW, TW=4+PW
  - FSM state typedef {IDLE, ACCUM}
  - round/saturate function, shared with other requantizers
- One natural sub-module: result_fifo (2-entry, parameterised width, count output).

Test Plan (IL=4, FL=16; tree LSB = 2^-32, so 1.0 = 0x1_0000_0000):
- Four beats of 1.0 (first on beat 0, last on beat 3), out_ready=1 → out_valid in cycle t+2 after last; out_data=0x40000, out_sat=0.
- Three beats of 3.0 → 9.0 exceeds range [-8,8) → out_data=0x7FFFF, out_sat=1. Same with -3.0 → out_data=0x80000, out_sat=1.
- Rounding, single-beat groups (first & last set):
  - in_data=0x8000 → out_data=0x00001.
  - in_data=0x7FFF → 0x00000.
  - in_data=-0x8000 → 0x00000.
  - in_data=-0x8001 → 0xFFFFF.
- out_ready=0, three back-to-back single-beat groups → two results held, in_ready=0 before the third beat is accepted. Release out_ready → results pop in order, in_ready returns to 1, third result appears, nothing lost.
- Protocol errors:
  - Beat without first in IDLE → no output, err=1.
  - New first mid-group → first group discarded, only the second result appears, err stays 1 until reset.
- Reset asserted one cycle after a last beat → no out_valid afterwards, all outputs at reset values, next well-formed group produces a correct result.
